// File: rtl/serial_adder.sv
// Bit-serial adder: adds a+b+cin one bit per clock, LSB first, through a
// full adder built from two half adders and an OR, with a 1-bit carry register.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // Returns {carry, sum}; carry is the OR of the two half-adder carries.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        logic [1:0] h0;
        logic [1:0] h1;
        h0 = half_add(x, y);
        h1 = half_add(h0[0], ci);
        return {h0[1] | h1[1], h1[0]};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       fa_s;

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        fa_s    = full_add(a_sr_q[0], b_sr_q[0], carry_q);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = S_ADD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADD: begin
                a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
                res_d   = {fa_s[0], res_q[WIDTH-1:1]};
                carry_d = fa_s[1];
                cnt_d   = cnt_q + CW'(1'b1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = {fa_s[0], res_q[WIDTH-1:1]};
                    cout_d  = fa_s[1];
                    state_d = S_DONE;
                end else begin
                    state_d = S_ADD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_ADD);
        done_d = (state_d == S_DONE);
    end

    // State and output registers; reset clears everything regardless of state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; captured on the accepting start edge.
REQ-006 b  input  WIDTH  operand B; captured on the accepting start edge.
REQ-007 cin  input  1  carry-in; captured on the accepting start edge.
REQ-008 busy  output  1  high while bits are being added (state ADD).
REQ-009 done  output  1  one-cycle pulse marking sum/cout valid and newly updated.
REQ-010 sum  output  WIDTH  registered result, a+b+cin modulo 2^WIDTH.
REQ-011 cout  output  1  registered carry-out of the WIDTH-bit addition.

Function
REQ-012 The block SHALL add one bit per clock, LSB first, with a bit-level half-adder pair plus an OR forming a full adder, and a 1-bit carry register.
REQ-013 The FSM SHALL have states IDLE, ADD and DONE, registered, with no other reachable state.
REQ-014 IDLE: when start=1, the block SHALL load a, b into internal shift registers, load carry with cin, clear the bit counter and go to ADD; otherwise it stays in IDLE.
REQ-015 ADD: each edge SHALL compute s=a_sr[0]^b_sr[0]^carry and the new carry as majority(a_sr[0],b_sr[0],carry), shift both operand registers right by one, shift s into the MSB of an internal result register, and increment the counter.
REQ-016 ADD SHALL last exactly WIDTH edges; on the WIDTH-th edge the block SHALL copy the completed result to sum and the final carry to cout, and go to DONE.
REQ-017 DONE SHALL last exactly one cycle with done=1, then go to IDLE unconditionally.
REQ-018 Latency: start accepted at edge 0 SHALL give done=1 in the cycle after edge WIDTH, and busy=1 in the cycles after edges 0..WIDTH-1.
REQ-019 start while in ADD or DONE SHALL be ignored; operands are not recaptured and the running addition is unaffected.
REQ-020 Changes on a, b or cin after the accepting edge SHALL NOT affect the result.
REQ-021 sum and cout SHALL change only on the edge entering DONE and hold their values through IDLE and the following ADD until the next DONE.
REQ-022 busy and done SHALL never be high together; done SHALL never be high for two consecutive cycles.
REQ-023 Minimum spacing between accepted starts SHALL be WIDTH+2 cycles; start held high continuously SHALL give back-to-back operations at that spacing.
REQ-024 The bit counter SHALL be clog2(WIDTH+1) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-025 rst=1 on an edge SHALL force state IDLE and busy=0, done=0, sum=0, cout=0, and clear the carry, counter and all shift registers, regardless of state.
REQ-026 rst SHALL take priority over start on the same edge; a reset mid-ADD SHALL abandon the operation with no done pulse.
REQ-027 The first start SHALL be accepted on the first edge with rst=0.

Verification
REQ-028 WIDTH=8, a=8'hFF, b=8'h01, cin=0 -> done 8 cycles after the start edge, sum=8'h00, cout=1.
REQ-029 a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0; a=8'hA5, b=8'h5A, cin=0 -> sum=8'hFF, cout=0; a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-030 Pulse start again at cycle 3 of ADD with different a, b -> ignored; first result correct; busy stays high for exactly 8 cycles.
REQ-031 Assert rst at cycle 4 of ADD -> next cycle busy=0, done=0, sum=0, cout=0; no done pulse follows; a new start then completes correctly.
REQ-032 Hold start=1 for 30 cycles with fixed operands -> done pulses every 10 cycles, sum stable between pulses, done and busy never high together.
REQ-033 Randomised run, WIDTH=8 and WIDTH=16, 1000 operations -> {cout,sum} equals a+b+cin for every done pulse.
